// File: rtl/wave_gen_pkg.sv
// Shared definitions for the pushbutton conditioner.
//   - Button index constants, bit order {center, right, left, down, up}.
//   - NUM_BTNS: number of conditioned buttons.
//   - btn_state_t: per-button press/auto-repeat state.
package wave_gen_pkg;

  localparam int NUM_BTNS   = 5;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } btn_state_t;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton channel: 2-flop synchronizer, debouncer and press/auto-repeat
// state machine.
// Ports:
//   clk        system clock, all state on its rising edge
//   rst_n      asynchronous active-low reset
//   raw        raw asynchronous button level (active high)
//   repeat_en  global auto-repeat enable
//   level      debounced button level
//   pulse      single-cycle press / auto-repeat pulse (registered)
module btn_channel
  import wave_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 2_000_000,
  parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 10_000_000,
  parameter bit REPEAT_ENABLE        = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic pulse
);

  localparam int DW    = cnt_width(DEBOUNCE_CYCLES);
  localparam int DLY_W = cnt_width(REPEAT_DELAY_CYCLES);
  localparam int PER_W = cnt_width(REPEAT_PERIOD_CYCLES);
  localparam int TW    = (DLY_W > PER_W) ? DLY_W : PER_W;

  // The count "reaches" N on the edge where it would step from N-1 to N.
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
    end
  end

  assign sync = sync_reg[1];

  // ---------------------------------------------------------------------------
  // Debouncer: level follows sync only after sync has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] deb_cnt_reg;
  logic          level_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_reg <= '0;
      level_reg   <= 1'b0;
    end else if (sync != level_reg) begin
      if (deb_cnt_reg == DEB_LAST) begin
        level_reg   <= sync;
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg != '1) begin
        deb_cnt_reg <= deb_cnt_reg + DW'(1);
      end
    end else begin
      deb_cnt_reg <= '0;
    end
  end

  assign level = level_reg;

  // ---------------------------------------------------------------------------
  // Press / auto-repeat FSM
  // ---------------------------------------------------------------------------
  btn_state_t    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          pulse_reg, pulse_next;
  logic          counting;

  assign counting = repeat_en && REPEAT_ENABLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RELEASED;
      timer_reg <= '0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      pulse_reg <= pulse_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pulse_next = 1'b0;

    if (!level_reg) begin
      // A release wins over everything, including a repeat due this edge.
      state_next = RELEASED;
      timer_next = '0;
    end else begin
      case (state_reg)
        RELEASED: begin
          state_next = HELD_DELAY;
          timer_next = '0;
          pulse_next = 1'b1;
        end

        HELD_DELAY: begin
          if (!counting) begin
            timer_next = '0;
          end else if (timer_reg == DLY_LAST) begin
            state_next = HELD_REPEAT;
            timer_next = '0;
            pulse_next = 1'b1;
          end else if (timer_reg != '1) begin
            timer_next = timer_reg + TW'(1);
          end
        end

        HELD_REPEAT: begin
          if (!counting) begin
            // Re-enabling repeat must wait out the full initial delay again.
            state_next = HELD_DELAY;
            timer_next = '0;
          end else if (timer_reg == PER_LAST) begin
            timer_next = '0;
            pulse_next = 1'b1;
          end else if (timer_reg != '1) begin
            timer_next = timer_reg + TW'(1);
          end
        end

        default: begin
          state_next = RELEASED;
          timer_next = '0;
        end
      endcase
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/button_conditioner.sv
// Five-button conditioner: per-button synchronize, debounce and press /
// auto-repeat pulse generation; buttons are independent and never arbitrated.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   btn_raw     raw button levels {center, right, left, down, up}
//   repeat_en   global auto-repeat enable
//   btn_up .. btn_center  single-cycle press/repeat pulses
//   btn_level   debounced levels, same bit order as btn_raw
module button_conditioner
  import wave_gen_pkg::*;
#(
  parameter int                  DEBOUNCE_CYCLES      = 2_000_000,
  parameter int                  REPEAT_DELAY_CYCLES  = 50_000_000,
  parameter int                  REPEAT_PERIOD_CYCLES = 10_000_000,
  parameter logic [NUM_BTNS-1:0] REPEAT_MASK          = 5'b00011
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  input  logic                repeat_en,
  output logic                btn_up,
  output logic                btn_down,
  output logic                btn_left,
  output logic                btn_right,
  output logic                btn_center,
  output logic [NUM_BTNS-1:0] btn_level
);

  logic [NUM_BTNS-1:0] pulses;
  logic [NUM_BTNS-1:0] levels;

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
      btn_channel #(
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
        .REPEAT_ENABLE       (REPEAT_MASK[gi])
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (btn_raw[gi]),
        .repeat_en(repeat_en),
        .level    (levels[gi]),
        .pulse    (pulses[gi])
      );
    end
  endgenerate

  assign btn_up     = pulses[BTN_UP];
  assign btn_down   = pulses[BTN_DOWN];
  assign btn_left   = pulses[BTN_LEFT];
  assign btn_right  = pulses[BTN_RIGHT];
  assign btn_center = pulses[BTN_CENTER];
  assign btn_level  = levels;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a behavioural reference model.
module tb_button_conditioner;

  localparam int         DEB  = 4;
  localparam int         DLY  = 10;
  localparam int         PER  = 3;
  localparam logic [4:0] MASK = 5'b00011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_raw = '0;
  logic       repeat_en = 1'b0;
  logic       btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [4:0] btn_level;
  logic [4:0] pulses;

  assign pulses = {btn_center, btn_right, btn_left, btn_down, btn_up};

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES     (DEB),
    .REPEAT_DELAY_CYCLES (DLY),
    .REPEAT_PERIOD_CYCLES(PER),
    .REPEAT_MASK         (MASK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .repeat_en (repeat_en),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_center(btn_center),
    .btn_level (btn_level)
  );

  // ---------------------------------------------------------------------------
  // Reference model. Per button: raw is seen two edges late; the level flips
  // once the seen value has disagreed with it for DEB consecutive edges; one
  // edge after the level rises a press pulse appears; while held and enabled,
  // pulses follow after DLY enabled edges, then every PER enabled edges.
  // ---------------------------------------------------------------------------
  int m_seen_a[5], m_seen_b[5], m_run[5], m_lvl[5], m_phase[5], m_cnt[5], m_pulse[5];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        m_seen_a[i] = 0; m_seen_b[i] = 0; m_run[i] = 0; m_lvl[i] = 0;
        m_phase[i]  = 0; m_cnt[i]    = 0; m_pulse[i] = 0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        m_pulse[i] = 0;
        if (m_lvl[i] == 0) begin
          m_phase[i] = 0;
          m_cnt[i]   = 0;
        end else if (m_phase[i] == 0) begin
          m_phase[i] = 1;
          m_cnt[i]   = 0;
          m_pulse[i] = 1;
        end else if (!(repeat_en && MASK[i])) begin
          m_phase[i] = 1;
          m_cnt[i]   = 0;
        end else begin
          m_cnt[i]++;
          if (m_cnt[i] == ((m_phase[i] == 1) ? DLY : PER)) begin
            m_pulse[i] = 1;
            m_cnt[i]   = 0;
            m_phase[i] = 2;
          end
        end
        if (m_seen_b[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i] = m_seen_b[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_seen_b[i] = m_seen_a[i];
        m_seen_a[i] = int'(btn_raw[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers (all called from the single stimulus process)
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_fail = 0;
  int edge_now;
  int pcnt[5];

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (edge %0d)", name, got, exp, edge_now);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock: compare against the model 1 time unit after the edge, then
  // return at edge+2, where the caller drives new inputs.
  task automatic step();
    logic [4:0] ml, mp;
    @(posedge clk);
    #1;
    edge_now++;
    for (int i = 0; i < 5; i++) begin
      ml[i] = (m_lvl[i] != 0);
      mp[i] = (m_pulse[i] != 0);
      if (pulses[i] === 1'b1) pcnt[i]++;
    end
    chk("model_level", btn_level, ml);
    chk("model_pulse", pulses, mp);
    $display("edge %0d raw=%b en=%b level=%b pulse=%b", edge_now, btn_raw, repeat_en, btn_level, pulses);
    #1;
  endtask

  task automatic run_to(input int e);
    while (edge_now < e) step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int base[5];
  task automatic snap();
    for (int i = 0; i < 5; i++) base[i] = pcnt[i];
  endtask

  initial begin
    for (int i = 0; i < 5; i++) pcnt[i] = 0;
    edge_now = -100;

    // Reset state
    idle(3);
    chk("reset_level", btn_level, 5'b00000);
    chk("reset_pulse", pulses, 5'b00000);
    rst_n = 1'b1;
    idle(3);

    // Clean press on up, repeat disabled
    btn_raw = 5'b00001; edge_now = -1; snap();
    run_to(4);  chk("clean_level_e4", btn_level, 5'b00000);
    run_to(5);  chk("clean_level_e5", btn_level, 5'b00001);
                chk("clean_pulse_e5", pulses, 5'b00000);
    run_to(6);  chk("clean_pulse_e6", pulses, 5'b00001);
    run_to(7);  chk("clean_pulse_e7", pulses, 5'b00000);
    run_to(20); chk_int("clean_up_count", pcnt[0] - base[0], 1);
    btn_raw = 5'b00000; idle(12);
    chk_int("clean_no_release_pulse", pcnt[0] - base[0], 1);

    // Bounce: 1,0,1,0 then stable high from edge 4
    btn_raw = 5'b00001; edge_now = -1; snap();
    step(); btn_raw = 5'b00000;
    step(); btn_raw = 5'b00001;
    step(); btn_raw = 5'b00000;
    step(); btn_raw = 5'b00001;
    run_to(8);  chk("bounce_level_e8", btn_level, 5'b00000);
    run_to(9);  chk("bounce_level_e9", btn_level, 5'b00001);
    run_to(10); chk("bounce_pulse_e10", pulses, 5'b00001);
    run_to(20); chk_int("bounce_up_count", pcnt[0] - base[0], 1);
    btn_raw = 5'b00000; idle(12);

    // Auto-repeat on up, center single pulse; release collides with a repeat
    repeat_en = 1'b1;
    btn_raw = 5'b10001; edge_now = -1; snap();
    run_to(6);  chk("rep_press_e6", pulses, 5'b10001);
    run_to(15); chk("rep_none_e15", pulses, 5'b00000);
    run_to(16); chk("rep_first_e16", pulses, 5'b00001);
    run_to(19); chk("rep_period_e19", pulses, 5'b00001);
    run_to(21); btn_raw = 5'b00000;
    run_to(22); chk("rep_period_e22", pulses, 5'b00001);
    run_to(25); chk("rep_period_e25", pulses, 5'b00001);
    run_to(27); chk("rep_level_fall_e27", btn_level, 5'b00000);
    run_to(28); chk("rep_collision_e28", pulses, 5'b00000);
    run_to(35);
    chk_int("rep_up_count", pcnt[0] - base[0], 5);
    chk_int("rep_center_count", pcnt[4] - base[4], 1);

    // repeat_en dropped mid-repeat, re-enabled later
    btn_raw = 5'b00001; edge_now = -1;
    run_to(16); chk("en_first_e16", pulses, 5'b00001);
    run_to(19); chk("en_period_e19", pulses, 5'b00001);
    run_to(20); repeat_en = 1'b0; snap();
    run_to(29); repeat_en = 1'b1;
    run_to(38); chk("en_wait_e38", pulses, 5'b00000);
    run_to(39); chk("en_resume_e39", pulses, 5'b00001);
    chk_int("en_gap_count", pcnt[0] - base[0], 1);
    run_to(42); chk("en_period_e42", pulses, 5'b00001);
    btn_raw = 5'b00000; repeat_en = 1'b0; idle(12);

    // Simultaneous up+down, then reset mid-hold
    btn_raw = 5'b00011; edge_now = -1;
    run_to(6);  chk("simul_pulse_e6", pulses, 5'b00011);
    run_to(10); chk("simul_level_e10", btn_level, 5'b00011);
    rst_n = 1'b0;
    #1;
    chk("rst_async_level", btn_level, 5'b00000);
    chk("rst_async_pulse", pulses, 5'b00000);
    #1;
    idle(2);
    rst_n = 1'b1; edge_now = -1; snap();
    run_to(1);  chk("post_rst_pulse_e1", pulses, 5'b00000);
    run_to(4);  chk("post_rst_level_e4", btn_level, 5'b00000);
    run_to(5);  chk("post_rst_level_e5", btn_level, 5'b00011);
    run_to(6);  chk("post_rst_pulse_e6", pulses, 5'b00011);
    run_to(20);
    chk_int("post_rst_up_count", pcnt[0] - base[0], 1);
    chk_int("post_rst_down_count", pcnt[1] - base[1], 1);
    btn_raw = 5'b00000; idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
